// File: rtl/calc_req_queue_if.sv
// Request/issue/response/error bundle of the calculator request front-end.
// The slave modport is the queue side; the master modport is its environment.
interface calc_req_queue_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [3:0]    req_cmd_in;
  logic [31:0]   req_data_in;
  logic [3:0]    req_d1;
  logic [3:0]    req_d2;
  logic [3:0]    req_r1;
  logic [1:0]    req_tag_in;

  logic          iss_valid;
  logic          iss_ready;
  logic [3:0]    iss_cmd;
  logic [31:0]   iss_data;
  logic [3:0]    iss_d1;
  logic [3:0]    iss_d2;
  logic [3:0]    iss_r1;
  logic [1:0]    iss_tag;

  logic [1:0]    out_resp;
  logic [1:0]    out_tag;

  logic          err_valid;
  logic [1:0]    err_tag;
  logic [1:0]    err_code;
  logic [CW-1:0] count;

  modport master (
    output req_cmd_in, req_data_in, req_d1, req_d2, req_r1, req_tag_in,
    output iss_ready, out_resp, out_tag,
    input  iss_valid, iss_cmd, iss_data, iss_d1, iss_d2, iss_r1, iss_tag,
    input  err_valid, err_tag, err_code, count
  );

  modport slave (
    input  req_cmd_in, req_data_in, req_d1, req_d2, req_r1, req_tag_in,
    input  iss_ready, out_resp, out_tag,
    output iss_valid, iss_cmd, iss_data, iss_d1, iss_d2, iss_r1, iss_tag,
    output err_valid, err_tag, err_code, count
  );
endinterface

// File: rtl/calc_req_queue.sv
// Per-port request queue: tag scoreboard, in-order FIFO and issue handshake.
// Define CALC_REQ_HAZARD_EN to stall issue on register read-after-write hazards.
module calc_req_queue #(
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  calc_req_queue_if.slave  bus
);
  localparam int PW   = $clog2(DEPTH);
  localparam int CW   = PW + 1;
  localparam int NTAG = 4;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef struct packed {
    logic [3:0]  cmd;
    logic [31:0] data;
    logic [3:0]  d1;
    logic [3:0]  d2;
    logic [3:0]  r1;
    logic [1:0]  tag;
  } entry_t;

  entry_t          mem_r [DEPTH];
  entry_t          head_r;
  entry_t          head_nxt_s;
  entry_t          req_s;
  logic [PW-1:0]   wr_ptr_r;
  logic [PW-1:0]   rd_ptr_r;
  logic [PW-1:0]   wr_ptr_nxt_s;
  logic [PW-1:0]   rd_ptr_nxt_s;
  logic [CW-1:0]   count_r;
  logic [CW-1:0]   count_nxt_s;
  logic [NTAG-1:0] busy_r;
  logic [NTAG-1:0] issued_r;
  logic [NTAG-1:0] busy_nxt_s;
  logic [NTAG-1:0] issued_nxt_s;
  logic            iss_valid_r;
  logic            iss_valid_nxt_s;
  logic            stall_nxt_s;
  logic            err_valid_r;
  logic [1:0]      err_tag_r;
  logic [1:0]      err_code_r;
  logic            req_valid_s;
  logic            retire_s;
  logic            dup_s;
  logic            full_s;
  logic            push_s;
  logic            pop_s;

`ifdef CALC_REQ_HAZARD_EN
  logic [NTAG-1:0][3:0] dst_r;
  logic [NTAG-1:0][3:0] dst_nxt_s;

  function automatic logic raw_hazard(
    input logic [3:0]           src1,
    input logic [3:0]           src2,
    input logic [NTAG-1:0]      live,
    input logic [NTAG-1:0][3:0] dst
  );
    logic hit;
    hit = 1'b0;
    for (int t = 0; t < NTAG; t++) begin
      hit = hit | (live[t] & ((dst[t] == src1) | (dst[t] == src2)));
    end
    return hit;
  endfunction
`endif

  // Pack the incoming request into a FIFO entry.
  always_comb begin
    req_s = {bus.req_cmd_in, bus.req_data_in, bus.req_d1, bus.req_d2, bus.req_r1, bus.req_tag_in};
  end

  // Scoreboard update: retire first so a same-edge request may reuse the tag.
  always_comb begin
    req_valid_s  = (bus.req_cmd_in != 4'h0);
    pop_s        = iss_valid_r & bus.iss_ready;
    retire_s     = (bus.out_resp != 2'b00) & busy_r[bus.out_tag] & issued_r[bus.out_tag];
    busy_nxt_s   = busy_r;
    issued_nxt_s = issued_r;
`ifdef CALC_REQ_HAZARD_EN
    dst_nxt_s    = dst_r;
`endif
    if (retire_s) begin
      busy_nxt_s[bus.out_tag]   = 1'b0;
      issued_nxt_s[bus.out_tag] = 1'b0;
    end else begin
      busy_nxt_s[bus.out_tag]   = busy_r[bus.out_tag];
    end
    dup_s  = req_valid_s & busy_nxt_s[bus.req_tag_in];
    // Full is judged on the pre-edge count; a same-edge pop does not help.
    full_s = req_valid_s & ~dup_s & (count_r == DEPTH_C);
    push_s = req_valid_s & ~dup_s & ~full_s;
    if (pop_s) begin
      issued_nxt_s[head_r.tag] = 1'b1;
`ifdef CALC_REQ_HAZARD_EN
      dst_nxt_s[head_r.tag]    = head_r.r1;
`endif
    end else begin
      issued_nxt_s[head_r.tag] = issued_nxt_s[head_r.tag];
    end
    if (push_s) begin
      busy_nxt_s[bus.req_tag_in]   = 1'b1;
      issued_nxt_s[bus.req_tag_in] = 1'b0;
    end else begin
      busy_nxt_s[bus.req_tag_in]   = busy_nxt_s[bus.req_tag_in];
    end
  end

  // FIFO pointer, occupancy and next-head selection.
  always_comb begin
    wr_ptr_nxt_s = push_s ? (wr_ptr_r + PW'(1)) : wr_ptr_r;
    rd_ptr_nxt_s = pop_s  ? (rd_ptr_r + PW'(1)) : rd_ptr_r;
    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count_r + CW'(1);
      2'b01:   count_nxt_s = count_r - CW'(1);
      default: count_nxt_s = count_r;
    endcase
    // A push into a queue that will hold only that entry bypasses the memory.
    if (count_nxt_s == {CW{1'b0}}) begin
      head_nxt_s = head_r;
    end else if (push_s && (wr_ptr_r == rd_ptr_nxt_s)) begin
      head_nxt_s = req_s;
    end else begin
      head_nxt_s = mem_r[rd_ptr_nxt_s];
    end
  end

  // Issue qualification for the next cycle, including the optional RAW stall.
  always_comb begin
`ifdef CALC_REQ_HAZARD_EN
    stall_nxt_s = raw_hazard(head_nxt_s.d1, head_nxt_s.d2, busy_nxt_s & issued_nxt_s, dst_nxt_s);
`else
    stall_nxt_s = 1'b0;
`endif
    iss_valid_nxt_s = (count_nxt_s != {CW{1'b0}}) & ~stall_nxt_s;
  end

  // FIFO storage; entries are only read while valid, so no reset is needed.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= req_s;
    end
  end

  // Control state, scoreboard and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_r    <= {PW{1'b0}};
      rd_ptr_r    <= {PW{1'b0}};
      count_r     <= {CW{1'b0}};
      busy_r      <= {NTAG{1'b0}};
      issued_r    <= {NTAG{1'b0}};
`ifdef CALC_REQ_HAZARD_EN
      dst_r       <= '0;
`endif
      head_r      <= '0;
      iss_valid_r <= 1'b0;
      err_valid_r <= 1'b0;
      err_tag_r   <= 2'b00;
      err_code_r  <= 2'b00;
    end else begin
      wr_ptr_r    <= wr_ptr_nxt_s;
      rd_ptr_r    <= rd_ptr_nxt_s;
      count_r     <= count_nxt_s;
      busy_r      <= busy_nxt_s;
      issued_r    <= issued_nxt_s;
`ifdef CALC_REQ_HAZARD_EN
      dst_r       <= dst_nxt_s;
`endif
      head_r      <= head_nxt_s;
      iss_valid_r <= iss_valid_nxt_s;
      err_valid_r <= dup_s | full_s;
      err_tag_r   <= (dup_s | full_s) ? bus.req_tag_in : 2'b00;
      err_code_r  <= dup_s ? 2'b01 : (full_s ? 2'b10 : 2'b00);
    end
  end

  assign bus.iss_valid = iss_valid_r;
  assign bus.iss_cmd   = head_r.cmd;
  assign bus.iss_data  = head_r.data;
  assign bus.iss_d1    = head_r.d1;
  assign bus.iss_d2    = head_r.d2;
  assign bus.iss_r1    = head_r.r1;
  assign bus.iss_tag   = head_r.tag;
  assign bus.err_valid = err_valid_r;
  assign bus.err_tag   = err_tag_r;
  assign bus.err_code  = err_code_r;
  assign bus.count     = count_r;
endmodule

// File: tb/tb_calc_req_queue.sv
// Bench for calc_req_queue: DEPTH=4 and DEPTH=2 instances on shared stimulus,
// checked against a queue-based reference model.
module tb_calc_req_queue;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  cmd, d1, d2, r1;
  logic [31:0] data;
  logic [1:0]  tag, oresp, otag;
  logic        ready;
  int          checks = 0;
  int          errors = 0;

  calc_req_queue_if #(.DEPTH(4)) bus4 ();
  calc_req_queue_if #(.DEPTH(2)) bus2 ();

  assign bus4.req_cmd_in = cmd;   assign bus2.req_cmd_in = cmd;
  assign bus4.req_data_in = data; assign bus2.req_data_in = data;
  assign bus4.req_d1 = d1;        assign bus2.req_d1 = d1;
  assign bus4.req_d2 = d2;        assign bus2.req_d2 = d2;
  assign bus4.req_r1 = r1;        assign bus2.req_r1 = r1;
  assign bus4.req_tag_in = tag;   assign bus2.req_tag_in = tag;
  assign bus4.iss_ready = ready;  assign bus2.iss_ready = ready;
  assign bus4.out_resp = oresp;   assign bus2.out_resp = oresp;
  assign bus4.out_tag = otag;     assign bus2.out_tag = otag;

  calc_req_queue #(.DEPTH(4)) u_dut4 (.clk(clk), .rst(rst), .bus(bus4.slave));
  calc_req_queue #(.DEPTH(2)) u_dut2 (.clk(clk), .rst(rst), .bus(bus2.slave));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  cmd;
    logic [31:0] data;
    logic [3:0]  d1;
    logic [3:0]  d2;
    logic [3:0]  r1;
    logic [1:0]  tag;
  } ent_t;

  ent_t       mq [2][$];
  bit         mbusy [2][4];
  bit         missued [2][4];
  logic [3:0] mdst [2][4];
  int         mdepth [2];
  bit         xerr_v [2];
  logic [1:0] xerr_code [2];
  logic [1:0] xerr_tag [2];

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  function automatic bit m_stall(input int i);
    bit s;
    s = 1'b0;
    if (mq[i].size() == 0) return 1'b0;
`ifdef CALC_REQ_HAZARD_EN
    for (int t = 0; t < 4; t++)
      if (mbusy[i][t] && missued[i][t] && (mdst[i][t] == mq[i][0].d1 || mdst[i][t] == mq[i][0].d2))
        s = 1'b1;
`endif
    return s;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      mq[i].delete();
      for (int t = 0; t < 4; t++) begin
        mbusy[i][t] = 1'b0; missued[i][t] = 1'b0; mdst[i][t] = 4'h0;
      end
      xerr_v[i] = 1'b0; xerr_code[i] = 2'b00; xerr_tag[i] = 2'b00;
    end
  endtask

  // Advance model instance i across the coming clock edge using current inputs.
  task automatic step_model(input int i);
    bit   pop, full, push;
    ent_t h;
    pop  = (mq[i].size() != 0) && !m_stall(i) && ready;
    full = (mq[i].size() == mdepth[i]);
    push = 1'b0;
    xerr_v[i] = 1'b0; xerr_code[i] = 2'b00; xerr_tag[i] = 2'b00;
    if (oresp != 2'b00 && mbusy[i][otag] && missued[i][otag]) begin
      mbusy[i][otag] = 1'b0; missued[i][otag] = 1'b0;
    end
    if (cmd != 4'h0) begin
      if (mbusy[i][tag]) begin
        xerr_v[i] = 1'b1; xerr_code[i] = 2'b01; xerr_tag[i] = tag;
      end else if (full) begin
        xerr_v[i] = 1'b1; xerr_code[i] = 2'b10; xerr_tag[i] = tag;
      end else push = 1'b1;
    end
    if (pop) begin
      h = mq[i].pop_front();
      missued[i][h.tag] = 1'b1;
      mdst[i][h.tag] = h.r1;
    end
    if (push) begin
      mq[i].push_back({cmd, data, d1, d2, r1, tag});
      mbusy[i][tag] = 1'b1; missued[i][tag] = 1'b0;
    end
  endtask

  task automatic check_inst(input int i, input logic v, input logic [3:0] c, input logic [31:0] dt,
                            input logic [3:0] a, input logic [3:0] b, input logic [3:0] r,
                            input logic [1:0] t, input logic ev, input logic [1:0] ec,
                            input logic [1:0] et, input logic [4:0] cnt);
    bit xv;
    xv = (mq[i].size() != 0) && !m_stall(i);
    chk($sformatf("iss_valid[%0d]", i), v, xv);
    if (xv) begin
      chk($sformatf("iss_cmd[%0d]", i), c, mq[i][0].cmd);
      chk($sformatf("iss_data[%0d]", i), dt, mq[i][0].data);
      chk($sformatf("iss_d1[%0d]", i), a, mq[i][0].d1);
      chk($sformatf("iss_d2[%0d]", i), b, mq[i][0].d2);
      chk($sformatf("iss_r1[%0d]", i), r, mq[i][0].r1);
      chk($sformatf("iss_tag[%0d]", i), t, mq[i][0].tag);
    end
    chk($sformatf("err_valid[%0d]", i), ev, xerr_v[i]);
    chk($sformatf("err_code[%0d]", i), ec, xerr_code[i]);
    chk($sformatf("err_tag[%0d]", i), et, xerr_tag[i]);
    chk($sformatf("count[%0d]", i), cnt, mq[i].size());
  endtask

  task automatic check_all();
    check_inst(0, bus4.iss_valid, bus4.iss_cmd, bus4.iss_data, bus4.iss_d1, bus4.iss_d2, bus4.iss_r1,
               bus4.iss_tag, bus4.err_valid, bus4.err_code, bus4.err_tag, 5'(bus4.count));
    check_inst(1, bus2.iss_valid, bus2.iss_cmd, bus2.iss_data, bus2.iss_d1, bus2.iss_d2, bus2.iss_r1,
               bus2.iss_tag, bus2.err_valid, bus2.err_code, bus2.err_tag, 5'(bus2.count));
  endtask

  task automatic chk_reset_outputs();
    chk("rst_valid4", bus4.iss_valid, 32'h0);
    chk("rst_fields4", {bus4.iss_cmd, bus4.iss_d1, bus4.iss_d2, bus4.iss_r1, bus4.iss_tag}, 32'h0);
    chk("rst_data4", bus4.iss_data, 32'h0);
    chk("rst_err4", {bus4.err_valid, bus4.err_code, bus4.err_tag}, 32'h0);
    chk("rst_count4", bus4.count, 32'h0);
    chk("rst_valid2", bus2.iss_valid, 32'h0);
    chk("rst_fields2", {bus2.iss_cmd, bus2.iss_d1, bus2.iss_d2, bus2.iss_r1, bus2.iss_tag}, 32'h0);
    chk("rst_data2", bus2.iss_data, 32'h0);
    chk("rst_err2", {bus2.err_valid, bus2.err_code, bus2.err_tag}, 32'h0);
    chk("rst_count2", bus2.count, 32'h0);
  endtask

  task automatic cycle();
    for (int i = 0; i < 2; i++) step_model(i);
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic set_req(input logic [3:0] c, input logic [1:0] t, input logic [31:0] dt,
                         input logic [3:0] a, input logic [3:0] b, input logic [3:0] r);
    cmd = c; tag = t; data = dt; d1 = a; d2 = b; r1 = r;
  endtask

  task automatic idle();
    cmd = 4'h0; oresp = 2'b00; otag = 2'b00;
  endtask

  task automatic retire(input logic [1:0] t);
    cmd = 4'h0; oresp = 2'b01; otag = t;
    cycle();
    oresp = 2'b00;
  endtask

  initial begin
    mdepth[0] = 4; mdepth[1] = 2;
    idle(); set_req(4'h0, 2'd0, 32'h0, 4'h0, 4'h0, 4'h0); ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs();
    rst = 1'b1;

    // Single request straight through.
    ready = 1'b1;
    set_req(4'h1, 2'd0, 32'h0000_0005, 4'h1, 4'h2, 4'h9);
    cycle();
    chk("t1_valid", bus4.iss_valid, 32'h1);
    chk("t1_data", bus4.iss_data, 32'h5);
    chk("t1_tag", bus4.iss_tag, 32'h0);
    idle(); cycle();
    chk("t1_count", bus4.count, 32'h0);
    chk("t1_valid_drop", bus4.iss_valid, 32'h0);
    retire(2'd0);

    // Duplicate tag.
    ready = 1'b0;
    set_req(4'h2, 2'd2, 32'h1234_0000, 4'hA, 4'hB, 4'hC); cycle();
    set_req(4'h3, 2'd2, 32'h5555_0000, 4'hA, 4'hB, 4'hC); cycle();
    chk("dup_valid", bus4.err_valid, 32'h1);
    chk("dup_code", bus4.err_code, 32'h1);
    chk("dup_tag", bus4.err_tag, 32'h2);
    chk("dup_count", bus4.count, 32'h1);
    idle(); cycle();
    chk("dup_pulse", bus4.err_valid, 32'h0);
    ready = 1'b1; cycle(); cycle();
    retire(2'd2);

    // Full queue on DEPTH=2, ignored retire of a queued tag, full plus pop.
    ready = 1'b0;
    set_req(4'h4, 2'd0, 32'h0A0A_0000, 4'hE, 4'hE, 4'h1); cycle();
    set_req(4'h5, 2'd1, 32'h0B0B_0000, 4'hE, 4'hE, 4'h2); cycle();
    set_req(4'h6, 2'd2, 32'h0C0C_0000, 4'hE, 4'hE, 4'h3); cycle();
    chk("full_valid2", bus2.err_valid, 32'h1);
    chk("full_code2", bus2.err_code, 32'h2);
    retire(2'd0);
    chk("retire_ign_count", bus4.count, 32'h3);
    ready = 1'b1;
    set_req(4'h7, 2'd3, 32'h0D0D_0000, 4'hE, 4'hE, 4'h4); cycle();
    chk("fullpop_code2", bus2.err_code, 32'h2);
    chk("fullpop_count2", bus2.count, 32'h1);
    idle(); repeat (6) cycle();
    for (int t = 0; t < 4; t++) retire(2'(t));

    // RAW hazard on r1=3, then same-edge retire and reuse of tag 1.
    ready = 1'b1;
    set_req(4'h1, 2'd0, 32'h1111_1111, 4'h5, 4'h6, 4'h3); cycle();
    set_req(4'h2, 2'd1, 32'h2222_2222, 4'h3, 4'h7, 4'h4); cycle();
    idle(); cycle();
    retire(2'd0);
    idle(); cycle();
    oresp = 2'b01; otag = 2'd1;
    set_req(4'h3, 2'd1, 32'h3333_3333, 4'h8, 4'h9, 4'h5); cycle();
    chk("same_edge_err", bus4.err_valid, 32'h0);
    chk("same_edge_count", bus4.count, 32'h1);
    idle(); cycle(); cycle();
    retire(2'd1);

    // Reset with requests queued, then a stale response.
    ready = 1'b0;
    set_req(4'h1, 2'd0, 32'hAAAA_0000, 4'h1, 4'h1, 4'h1); cycle();
    set_req(4'h2, 2'd2, 32'hBBBB_0000, 4'h2, 4'h2, 4'h2); cycle();
    set_req(4'h3, 2'd3, 32'hCCCC_0000, 4'h3, 4'h3, 4'h3); cycle();
    idle();
    rst = 1'b0;
    #1;
    model_reset();
    chk_reset_outputs();
    @(posedge clk);
    #1;
    rst = 1'b1;
    retire(2'd0);
    idle(); cycle();

    // Randomized traffic.
    for (int n = 0; n < 600; n++) begin
      cmd   = ($urandom_range(0, 9) < 6) ? 4'($urandom_range(1, 15)) : 4'h0;
      tag   = 2'($urandom_range(0, 3));
      data  = $urandom;
      d1    = 4'($urandom_range(0, 7));
      d2    = 4'($urandom_range(0, 7));
      r1    = 4'($urandom_range(0, 7));
      ready = ($urandom_range(0, 3) != 0);
      oresp = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      otag  = 2'($urandom_range(0, 3));
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
